// File: rtl/spi_pattern_responder.sv
// spi_pattern_responder: claims SPI transactions opened by CMD_BYTE and
// answers each data byte with a pattern chosen by the configuration byte
// (loopback, invert, counter, delayed loopback).
// Optional build macro: SPI_PATTERN_STATS_EN (per-transaction byte counter
// whose low byte becomes the configuration-byte response).
module spi_pattern_responder #(
    parameter logic [7:0] CMD_BYTE  = 8'hf1,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] ID_BYTE   = 8'ha5,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pw_wdata,
    input  logic       pw_wcmd,
    input  logic       pw_wstb,
    input  logic       pw_end,
    output logic       pw_req,
    input  logic       pw_gnt,
    output logic [7:0] pw_rdata,
    output logic       pw_rstb
);

    typedef enum logic [1:0] {IDLE, CFG, RUN} state_t;

    state_t     state, state_next;
    logic [1:0] mode;
    logic [2:0] dly;
    logic [7:0] cnt;
    logic [2:0] prime;
    logic [7:0] dl [DEPTH];
    logic [7:0] tap;
    logic [7:0] resp;
    logic [7:0] cfg_resp;

    // pw_end overrides any strobe in the same cycle, so it masks every event.
    logic data_stb, cmd_hit, cmd_miss, accept, run_byte, cfg_byte;
    assign data_stb = pw_wstb & ~pw_wcmd & ~pw_end;
    assign cmd_hit  = pw_wstb & pw_wcmd & ~pw_end & (pw_wdata == CMD_BYTE);
    assign cmd_miss = pw_wstb & pw_wcmd & ~pw_end & (pw_wdata != CMD_BYTE);
    assign accept   = data_stb & (state != IDLE);
    assign run_byte = data_stb & (state == RUN);
    assign cfg_byte = data_stb & (state == CFG);

    // Delay field is clamped to the physical delay-line depth.
    function automatic logic [2:0] clamp_delay(input logic [2:0] field);
        return (field > 3'(DEPTH)) ? 3'(DEPTH) : field;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode; pw_end always returns to IDLE.
    always_comb begin
        state_next = state;
        if (pw_end) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (cmd_hit) state_next = CFG;
                CFG, RUN: begin
                    if (cmd_hit)       state_next = CFG;
                    else if (cmd_miss) state_next = IDLE;
                    else if (data_stb) state_next = RUN;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Request flop mirrors (state != IDLE) without combinational decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pw_req <= 1'b0;
        else        pw_req <= (state_next != IDLE);
    end

    // Mode and delay are captured from the configuration byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 2'd0;
            dly  <= 3'd0;
        end else if (cfg_byte) begin
            mode <= pw_wdata[1:0];
            dly  <= clamp_delay(pw_wdata[4:2]);
        end
    end

    // Byte counter, priming count and delay line; cleared at CFG entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 8'h00;
            prime <= 3'd0;
            for (int i = 0; i < DEPTH; i++) dl[i] <= 8'h00;
        end else if (cmd_hit) begin
            cnt   <= 8'h00;
            prime <= 3'd0;
            for (int i = 0; i < DEPTH; i++) dl[i] <= 8'h00;
        end else if (run_byte) begin
            cnt <= cnt + 8'h01;
            if (prime != 3'(DEPTH)) prime <= prime + 3'd1;
            dl[0] <= pw_wdata;
            for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
        end
    end

    // Delay-line tap: dl[0] holds byte k-1, so byte k-D sits in dl[D-1].
    always_comb begin
        tap = FILL_BYTE;
        for (int i = 0; i < DEPTH; i++) begin
            if (dly == 3'(i + 1)) tap = dl[i];
        end
    end

    // Response selection for the byte currently on pw_wdata.
    always_comb begin
        resp = pw_wdata;
        if (state == CFG) begin
            resp = cfg_resp;
        end else begin
            case (mode)
                2'd0: resp = pw_wdata;
                2'd1: resp = ~pw_wdata;
                2'd2: resp = cnt;
                default: begin
                    if (dly == 3'd0)       resp = pw_wdata;
                    else if (prime >= dly) resp = tap;
                    else                   resp = FILL_BYTE;
                end
            endcase
        end
    end

    // Registered response; rdata only changes when a strobe is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pw_rstb  <= 1'b0;
            pw_rdata <= 8'h00;
        end else begin
            pw_rstb <= accept & pw_gnt;
            if (accept & pw_gnt) pw_rdata <= resp;
        end
    end

`ifdef SPI_PATTERN_STATS_EN
    logic [15:0] byte_cnt;
    logic [15:0] last_count;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'h0001;
    endfunction

    // RUN data-byte counter, snapshotted into last_count at transaction end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= 16'h0000;
            last_count <= 16'h0000;
        end else begin
            if (cmd_hit)       byte_cnt <= 16'h0000;
            else if (run_byte) byte_cnt <= sat_inc16(byte_cnt);
            if (pw_end) last_count <= byte_cnt;
        end
    end

    assign cfg_resp = last_count[7:0];
`else
    assign cfg_resp = ID_BYTE;
`endif

endmodule

// File: tb/tb_spi_pattern_responder.sv
// Self-checking bench for spi_pattern_responder: expected responses are
// queued with their due cycle as stimulus is driven and compared by a monitor.
module tb_spi_pattern_responder;

    localparam logic [7:0] CMD   = 8'hf1;
    localparam logic [7:0] ID    = 8'ha5;
    localparam logic [7:0] FILL  = 8'h00;
    localparam int         DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] pw_wdata;
    logic       pw_wcmd;
    logic       pw_wstb;
    logic       pw_end;
    logic       pw_req;
    logic       pw_gnt;
    logic [7:0] pw_rdata;
    logic       pw_rstb;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference transaction model: 0 idle, 1 cfg, 2 run.
    int         mst = 0;
    int         run_cnt = 0;
    logic [7:0] last_cnt = 8'h00;

    spi_pattern_responder #(
        .CMD_BYTE(CMD), .DEPTH(DEPTH), .ID_BYTE(ID), .FILL_BYTE(FILL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd),
        .pw_wstb(pw_wstb), .pw_end(pw_end), .pw_req(pw_req), .pw_gnt(pw_gnt),
        .pw_rdata(pw_rdata), .pw_rstb(pw_rstb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Response monitor: every strobe must match the head of the queue on time.
    always @(negedge clk) begin
        exp_t e;
        if (pw_rstb === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rstb: rdata=%h at cycle %0d, no response expected", pw_rdata, cyc);
            end else begin
                e = q.pop_front();
                if (pw_rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL response: got %h at cycle %0d, expected %h at cycle %0d",
                             pw_rdata, cyc, e.data, e.due);
                end
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL missing_rstb: got no strobe at cycle %0d, expected %h", cyc, e.data);
        end
    end

    function automatic logic [7:0] cfg_resp();
`ifdef SPI_PATTERN_STATS_EN
        return last_cnt;
`else
        return ID;
`endif
    endfunction

    task automatic expect_resp(input logic [7:0] v);
        exp_t e;
        e.data = v;
        e.due  = cyc + 1;
        q.push_back(e);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        pw_wstb = 1'b1; pw_wcmd = 1'b1; pw_wdata = b; pw_end = 1'b0; pw_gnt = 1'b1;
        if (b == CMD) begin
            mst = 1;
            run_cnt = 0;
        end else begin
            mst = 0;
        end
    endtask

    task automatic send_data(input logic [7:0] d, input logic g, input logic [7:0] e);
        @(negedge clk);
        pw_wstb = 1'b1; pw_wcmd = 1'b0; pw_wdata = d; pw_end = 1'b0; pw_gnt = g;
        if (mst != 0 && g) expect_resp(e);
        if (mst == 2) run_cnt++;
        if (mst == 1) mst = 2;
    endtask

    task automatic send_cfg(input logic [7:0] c);
        send_data(c, 1'b1, cfg_resp());
    endtask

    task automatic end_txn();
        @(negedge clk);
        pw_wstb = 1'b0; pw_end = 1'b1;
        last_cnt = run_cnt[7:0];
        mst = 0;
        @(negedge clk);
        pw_end = 1'b0;
    endtask

    task automatic end_with_strobe(input logic [7:0] d);
        @(negedge clk);
        pw_wstb = 1'b1; pw_wcmd = 1'b0; pw_wdata = d; pw_end = 1'b1; pw_gnt = 1'b1;
        last_cnt = run_cnt[7:0];
        mst = 0;
        @(negedge clk);
        pw_wstb = 1'b0; pw_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pw_wstb = 1'b0; pw_end = 1'b0; pw_gnt = 1'b1;
        end
    endtask

    task automatic drain(input string name);
        idle(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 3;
        if (pw_req !== 1'b0)    begin errors++; $display("FAIL reset_req: got %b, expected 0", pw_req); end
        if (pw_rstb !== 1'b0)   begin errors++; $display("FAIL reset_rstb: got %b, expected 0", pw_rstb); end
        if (pw_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h, expected 00", pw_rdata); end
        rst_n = 1'b1;
        send_cmd(CMD);
        send_cfg(8'h00);
        send_data(8'h11, 1'b1, 8'h11);
        idle(2);
        checks++;
        if (pw_req !== 1'b1) begin errors++; $display("FAIL run_req: got %b, expected 1", pw_req); end
        // Strobe whose response is killed by an asynchronous reset mid-transaction.
        @(negedge clk);
        pw_wstb = 1'b1; pw_wcmd = 1'b0; pw_wdata = 8'h22; pw_gnt = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        mst = 0; run_cnt = 0; last_cnt = 8'h00;
        checks += 3;
        if (pw_req !== 1'b0)    begin errors++; $display("FAIL async_reset_req: got %b, expected 0", pw_req); end
        if (pw_rstb !== 1'b0)   begin errors++; $display("FAIL async_reset_rstb: got %b, expected 0", pw_rstb); end
        if (pw_rdata !== 8'h00) begin errors++; $display("FAIL async_reset_rdata: got %h, expected 00", pw_rdata); end
        @(negedge clk);
        pw_wstb = 1'b0;
        rst_n = 1'b1;
        send_cmd(CMD);
        send_cfg(8'h00);
        end_txn();
        drain("reset");
    endtask

    task automatic test_loopback_invert();
        send_cmd(CMD);
        send_cfg(8'h00);
        send_data(8'h12, 1'b1, 8'h12);
        send_data(8'h34, 1'b1, 8'h34);
        send_data(8'h56, 1'b1, 8'h56);
        end_txn();
        send_cmd(CMD);
        send_cfg(8'h01);
        send_data(8'h12, 1'b1, 8'hed);
        send_data(8'ha0, 1'b1, 8'h5f);
        end_txn();
        drain("loopback_invert");
    endtask

    task automatic test_counter_wrap();
        send_cmd(CMD);
        send_cfg(8'h02);
        for (int i = 0; i < 258; i++) send_data(8'(i * 7 + 3), 1'b1, 8'(i));
        end_txn();
        drain("counter_wrap");
    endtask

    task automatic test_delayed(input logic [7:0] cfg, input int d,
                                input logic [7:0] base, input int n);
        logic [7:0] hist [16];
        send_cmd(CMD);
        send_cfg(cfg);
        for (int k = 0; k < n; k++) begin
            hist[k] = base + 8'(k);
            send_data(hist[k], 1'b1, (k >= d) ? hist[k-d] : FILL);
        end
        drain("delayed");
    endtask

    task automatic test_handshake();
        send_cmd(CMD);
        send_cfg(8'h02);
        send_data(8'haa, 1'b1, 8'h00);
        send_data(8'hbb, 1'b0, 8'h01);
        send_data(8'hcc, 1'b1, 8'h02);
        checks++;
        if (pw_rdata !== 8'h00) begin errors++; $display("FAIL gnt_hold_rdata: got %h, expected 00", pw_rdata); end
        // Response still due while pw_end arrives in the following cycle.
        send_data(8'hdd, 1'b1, 8'h03);
        end_txn();
        drain("handshake");
        checks += 2;
        if (pw_rdata !== 8'h03) begin errors++; $display("FAIL rdata_hold: got %h, expected 03", pw_rdata); end
        if (pw_req !== 1'b0)    begin errors++; $display("FAIL end_req: got %b, expected 0", pw_req); end
    endtask

    task automatic test_end_coincident();
        send_cmd(CMD);
        send_cfg(8'h00);
        send_data(8'h5a, 1'b1, 8'h5a);
        end_with_strobe(8'h66);
        idle(2);
        checks++;
        if (pw_req !== 1'b0) begin errors++; $display("FAIL end_coincident_req: got %b, expected 0", pw_req); end
        send_data(8'h77, 1'b1, 8'h77);
        idle(2);
        checks++;
        if (pw_req !== 1'b0) begin errors++; $display("FAIL idle_data_req: got %b, expected 0", pw_req); end
        drain("end_coincident");
    endtask

    task automatic test_cmd_in_run();
        send_cmd(CMD);
        send_cfg(8'h00);
        send_data(8'h33, 1'b1, 8'h33);
        send_cmd(8'h55);
        idle(2);
        checks++;
        if (pw_req !== 1'b0) begin errors++; $display("FAIL foreign_cmd_req: got %b, expected 0", pw_req); end
        send_data(8'h44, 1'b1, 8'h44);
        send_cmd(CMD);
        send_cfg(8'h01);
        send_data(8'h0f, 1'b1, 8'hf0);
        send_cmd(CMD);
        idle(1);
        checks++;
        if (pw_req !== 1'b1) begin errors++; $display("FAIL recmd_req: got %b, expected 1", pw_req); end
        send_cfg(8'h00);
        send_data(8'h99, 1'b1, 8'h99);
        end_txn();
        drain("cmd_in_run");
    endtask

    task automatic test_stats();
        send_cmd(CMD);
        send_cfg(8'h00);
        for (int i = 0; i < 10; i++) send_data(8'h80 + 8'(i), 1'b1, 8'h80 + 8'(i));
        end_txn();
        send_cmd(CMD);
        send_cfg(8'h00);
        send_data(8'h3c, 1'b1, 8'h3c);
        end_txn();
        drain("stats");
    endtask

    initial begin
        rst_n = 1'b0; pw_wdata = 8'h00; pw_wcmd = 1'b0; pw_wstb = 1'b0;
        pw_end = 1'b0; pw_gnt = 1'b1;
        test_reset();
        test_loopback_invert();
        test_counter_wrap();
        test_delayed(8'h0f, 3, 8'h01, 6);
        test_delayed(8'h1f, 4, 8'h40, 8);
        test_delayed(8'h03, 0, 8'h70, 3);
        end_txn();
        test_handshake();
        test_end_coincident();
        test_cmd_in_run();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
